// File: rtl/mapper_writer_pkg.sv
// Shared types for the mapper register writer: FSM states and the queued request record.
package mapper_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IDX  = 2'd1,
    ST_DAT  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic        indexed;
    logic [15:0] addr;
    logic [3:0]  index;
    logic [7:0]  data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // The index phase writes the register number zero-extended onto the data bus.
  function automatic logic [7:0] index_byte(input logic [3:0] idx);
    return {4'b0000, idx};
  endfunction

endpackage

// File: rtl/mapper_writer_fifo.sv
// Small synchronous request FIFO with registered ready (not-full) and valid (not-empty).
module mapper_writer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             push, pop;

  // A push is judged against the flag registered last edge, so a pop while full
  // never opens room for a push on the same edge.
  assign push = in_valid & ready_q;
  assign pop  = out_ready & valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ready_d = (count_d != CW'(DEPTH));
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mapper_reg_writer.sv
// Queues mapper register writes and replays them as CPU bus cycles (direct or index/data).
// Optional shadow register file readback enabled by defining MAPPER_REG_WRITER_SHADOW_EN.
module mapper_reg_writer
  import mapper_writer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] INDEX_ADDR = 16'h8000,
  parameter logic [15:0] DATA_ADDR  = 16'hA000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_indexed,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_index,
  input  logic [7:0]  req_data,
  output logic [15:0] bus_ain,
  output logic [7:0]  bus_dout,
  output logic        bus_write,
  output logic        busy,
  output logic        done,
  output logic [15:0] write_count
`ifdef MAPPER_REG_WRITER_SHADOW_EN
  ,
  input  logic [3:0]  shadow_idx,
  output logic [7:0]  shadow_data
`endif
);

  req_t        in_req;
  req_t        fifo_data;
  logic        fifo_valid;
  logic        pop;
  logic        launch;

  state_e      state_q, state_d;
  state_e      after_gap_q, after_gap_d;
  logic [7:0]  cur_data_q, cur_data_d;
  logic [15:0] bus_ain_q, bus_ain_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        bus_write_q, bus_write_d;
  logic        done_q, done_d;
  logic [15:0] write_count_q, write_count_d;

  assign in_req = '{indexed: req_indexed, addr: req_addr, index: req_index, data: req_data};

  mapper_writer_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (req_valid),
    .in_ready  (req_ready),
    .in_data   (in_req),
    .out_valid (fifo_valid),
    .out_ready (pop),
    .out_data  (fifo_data)
  );

  always_comb begin
    state_d       = state_q;
    after_gap_d   = after_gap_q;
    cur_data_d    = cur_data_q;
    bus_ain_d     = bus_ain_q;
    bus_dout_d    = bus_dout_q;
    bus_write_d   = bus_write_q;
    write_count_d = write_count_q;
    done_d        = 1'b0;
    launch        = 1'b0;
    pop           = 1'b0;

    if (ce) begin
      unique case (state_q)
        ST_IDLE: launch = fifo_valid;
        ST_IDX: begin
          state_d     = ST_GAP;
          after_gap_d = ST_DAT;
          bus_write_d = 1'b0;
        end
        ST_DAT: begin
          state_d     = ST_GAP;
          after_gap_d = ST_IDLE;
          bus_write_d = 1'b0;
        end
        ST_GAP: begin
          if (after_gap_q == ST_DAT) begin
            state_d       = ST_DAT;
            bus_ain_d     = DATA_ADDR;
            bus_dout_d    = cur_data_q;
            bus_write_d   = 1'b1;
            write_count_d = write_count_q + 16'd1;
          end else begin
            // Chaining straight into the next queued request avoids an idle period.
            done_d  = 1'b1;
            state_d = ST_IDLE;
            launch  = fifo_valid;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (launch) begin
        pop           = 1'b1;
        cur_data_d    = fifo_data.data;
        bus_write_d   = 1'b1;
        write_count_d = write_count_q + 16'd1;
        if (fifo_data.indexed) begin
          state_d    = ST_IDX;
          bus_ain_d  = INDEX_ADDR;
          bus_dout_d = index_byte(fifo_data.index);
        end else begin
          state_d    = ST_DAT;
          bus_ain_d  = fifo_data.addr;
          bus_dout_d = fifo_data.data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      after_gap_q   <= ST_IDLE;
      cur_data_q    <= '0;
      bus_ain_q     <= '0;
      bus_dout_q    <= '0;
      bus_write_q   <= 1'b0;
      done_q        <= 1'b0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      after_gap_q   <= after_gap_d;
      cur_data_q    <= cur_data_d;
      bus_ain_q     <= bus_ain_d;
      bus_dout_q    <= bus_dout_d;
      bus_write_q   <= bus_write_d;
      done_q        <= done_d;
      write_count_q <= write_count_d;
    end
  end

  assign bus_ain     = bus_ain_q;
  assign bus_dout    = bus_dout_q;
  assign bus_write   = bus_write_q;
  assign done        = done_q;
  assign write_count = write_count_q;
  assign busy        = (state_q != ST_IDLE) | fifo_valid;

`ifdef MAPPER_REG_WRITER_SHADOW_EN
  logic [7:0] shadow_q [16];
  logic [3:0] shadow_sel_q;

  // Index is captured at pop time; the data lands when the indexed DAT phase begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= '{default: '0};
      shadow_sel_q <= '0;
    end else begin
      if (pop) shadow_sel_q <= fifo_data.index;
      if (ce && state_q == ST_GAP && after_gap_q == ST_DAT)
        shadow_q[shadow_sel_q] <= cur_data_q;
    end
  end

  assign shadow_data = shadow_q[shadow_idx];
`endif

endmodule

// File: tb/tb_mapper_reg_writer.sv
// Self-checking bench for mapper_reg_writer: directed vector table, corner sequences,
// and randomized traffic scored against a request-level reference model.
module tb_mapper_reg_writer;

  localparam logic [15:0] IDX_A = 16'h8000;
  localparam logic [15:0] DAT_A = 16'hA000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_indexed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_index = '0;
  logic [7:0]  req_data = '0;
  logic [15:0] bus_ain;
  logic [7:0]  bus_dout;
  logic        bus_write;
  logic        busy;
  logic        done;
  logic [15:0] write_count;
`ifdef MAPPER_REG_WRITER_SHADOW_EN
  logic [3:0]  shadow_idx = '0;
  logic [7:0]  shadow_data;
`endif

  int total = 0;
  int bad = 0;

  mapper_reg_writer #(
    .FIFO_DEPTH (DEPTH),
    .INDEX_ADDR (IDX_A),
    .DATA_ADDR  (DAT_A)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_indexed (req_indexed),
    .req_addr    (req_addr),
    .req_index   (req_index),
    .req_data    (req_data),
    .bus_ain     (bus_ain),
    .bus_dout    (bus_dout),
    .bus_write   (bus_write),
    .busy        (busy),
    .done        (done),
    .write_count (write_count)
`ifdef MAPPER_REG_WRITER_SHADOW_EN
    ,
    .shadow_idx  (shadow_idx),
    .shadow_data (shadow_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed per-clock vectors
  typedef struct {
    logic        ce;
    logic        valid;
    logic        indexed;
    logic [15:0] addr;
    logic [3:0]  index;
    logic [7:0]  data;
    logic        exp_write;
    logic [15:0] exp_ain;
    logic [7:0]  exp_dout;
    logic        exp_done;
    logic        exp_busy;
    logic        exp_ready;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs [14];

  task automatic apply_stimulus(input vec_t v, input int n);
    @(negedge clk);
    ce          = v.ce;
    req_valid   = v.valid;
    req_indexed = v.indexed;
    req_addr    = v.addr;
    req_index   = v.index;
    req_data    = v.data;
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d_write", n), 32'(bus_write), 32'(v.exp_write));
    check_output($sformatf("vec%0d_ain", n), 32'(bus_ain), 32'(v.exp_ain));
    check_output($sformatf("vec%0d_dout", n), 32'(bus_dout), 32'(v.exp_dout));
    check_output($sformatf("vec%0d_done", n), 32'(done), 32'(v.exp_done));
    check_output($sformatf("vec%0d_busy", n), 32'(busy), 32'(v.exp_busy));
    check_output($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(v.exp_ready));
    check_output($sformatf("vec%0d_wcount", n), 32'(write_count), 32'(v.exp_wc));
  endtask

  // Request-level reference model used during randomized traffic
  typedef struct packed {
    logic        indexed;
    logic [15:0] addr;
    logic [3:0]  index;
    logic [7:0]  data;
  } mreq_t;

  mreq_t       model_q [$];
  mreq_t       cur;
  bit          mon_en = 1'b0;
  bit          push_now = 1'b0;
  int          pushed_n = 0;
  int          started = 0;
  int          completed = 0;
  int          done_pend = 0;
  int          nxt_timer = 0;
  bit          in_prog = 1'b0;
  logic        last_w = 1'b0;
  logic [15:0] model_wc = '0;

  always @(posedge clk) begin
    logic        ce_s;
    bit          pn;
    logic        exp_w;
    logic        exp_d;
    logic [15:0] exp_ain;
    logic [7:0]  exp_dout;
    ce_s = ce;
    pn   = push_now;
    #1;
    if (!mon_en) begin
      in_prog = 0; nxt_timer = 0; done_pend = 0; started = 0; completed = 0;
      model_wc = '0; last_w = 1'b0;
    end else begin
      exp_w = 1'b0; exp_d = 1'b0; exp_ain = '0; exp_dout = '0;
      if (ce_s) begin
        if (done_pend > 0) begin
          done_pend--;
          if (done_pend == 0) begin exp_d = 1'b1; in_prog = 0; end
        end
        if (nxt_timer > 0) begin
          nxt_timer--;
          if (nxt_timer == 0) begin
            exp_w = 1'b1; exp_ain = DAT_A; exp_dout = cur.data; done_pend = 2;
          end
        end else if (!in_prog && (pushed_n - (pn ? 1 : 0) - started) > 0) begin
          if (model_q.size() == 0) begin
            check_output("model_underflow", 32'(model_q.size()), 32'd1);
          end else begin
            cur = model_q.pop_front();
            started++;
            in_prog = 1;
            exp_w = 1'b1;
            if (cur.indexed) begin
              exp_ain = IDX_A; exp_dout = {4'b0000, cur.index}; nxt_timer = 2;
            end else begin
              exp_ain = cur.addr; exp_dout = cur.data; done_pend = 2;
            end
          end
        end
        if (exp_w) model_wc = model_wc + 16'd1;
        check_output("rnd_write", 32'(bus_write), 32'(exp_w));
        if (exp_w) begin
          check_output("rnd_ain", 32'(bus_ain), 32'(exp_ain));
          check_output("rnd_dout", 32'(bus_dout), 32'(exp_dout));
        end
        check_output("rnd_done", 32'(done), 32'(exp_d));
      end else begin
        check_output("rnd_freeze_write", 32'(bus_write), 32'(last_w));
        check_output("rnd_idle_done", 32'(done), 32'd0);
      end
      if (exp_d) completed++;
      check_output("rnd_wcount", 32'(write_count), 32'(model_wc));
      check_output("rnd_busy", 32'(busy), 32'(pushed_n != completed));
      check_output("rnd_ready", 32'(req_ready), 32'((pushed_n - started) < DEPTH));
      last_w = bus_write;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values held while reset_n is low
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_write", 32'(bus_write), 32'd0);
    check_output("rst_ain", 32'(bus_ain), 32'd0);
    check_output("rst_dout", 32'(bus_dout), 32'd0);
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_wcount", 32'(write_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("rel_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("rel_ready_rise", 32'(req_ready), 32'd1);
    @(negedge clk);
    ce = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back direct writes, a frozen ce period, then one indexed write
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'hE000, 4'h0, 8'h05, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 4'h0, 8'hAA, 1'b1, 16'hE000, 8'h05, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'hE000, 8'h05, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b1, 16'h1234, 8'hAA, 1'b1, 1'b1, 1'b1, 16'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b1, 16'h1234, 8'hAA, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'h1234, 8'hAA, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'h1234, 8'hAA, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 4'hC, 8'h02, 1'b0, 16'h1234, 8'hAA, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b1, 16'h8000, 8'h0C, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'h8000, 8'h0C, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b1, 16'hA000, 8'h02, 1'b0, 1'b1, 1'b1, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'hA000, 8'h02, 1'b0, 1'b1, 1'b1, 16'd4};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'hA000, 8'h02, 1'b1, 1'b0, 1'b1, 16'd4};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0, 16'hA000, 8'h02, 1'b0, 1'b0, 1'b1, 16'd4};
    for (int i = 0; i < 14; i++) apply_stimulus(vecs[i], i);

`ifdef MAPPER_REG_WRITER_SHADOW_EN
    shadow_idx = 4'hC;
    #1;
    check_output("shadow_c", 32'(shadow_data), 32'h02);
`endif

    // FIFO fills with ce low; the fifth request waits for the first pop
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ce = 1'b0; req_valid = 1'b1; req_indexed = 1'b0;
      req_addr = 16'h6000 + 16'(i); req_data = 8'(i);
      @(posedge clk);
      #1;
      check_output($sformatf("full_ready%0d", i), 32'(req_ready), 32'(i < 3));
    end
    check_output("full_frozen_write", 32'(bus_write), 32'd0);
    check_output("full_frozen_wcount", 32'(write_count), 32'd4);
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    check_output("full_pop_ready", 32'(req_ready), 32'd1);
    check_output("full_pop_write", 32'(bus_write), 32'd1);
    check_output("full_pop_ain", 32'(bus_ain), 32'h6000);
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
    check_output("full_fifth_taken", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; ce = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_output("full_drain_busy", 32'(busy), 32'd0);
    check_output("full_drain_wcount", 32'(write_count), 32'd9);
    check_output("full_last_ain", 32'(bus_ain), 32'h6004);
    check_output("full_last_dout", 32'(bus_dout), 32'h04);

    // Reset asserted during the DAT phase of an indexed request, with a second one queued
    @(negedge clk);
    req_valid = 1'b1; req_indexed = 1'b1; req_index = 4'h3; req_data = 8'h77; req_addr = 16'h0;
    @(negedge clk);
    req_indexed = 1'b0; req_addr = 16'h2222; req_data = 8'h33;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("mid_dat_write", 32'(bus_write), 32'd1);
    check_output("mid_dat_ain", 32'(bus_ain), 32'hA000);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_write", 32'(bus_write), 32'd0);
    check_output("mid_rst_wcount", 32'(write_count), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_done", 32'(done), 32'd0);
    check_output("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid_rel_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check_output("mid_after_write", 32'(bus_write), 32'd0);
      check_output("mid_after_done", 32'(done), 32'd0);
      check_output("mid_after_busy", 32'(busy), 32'd0);
    end
    check_output("mid_after_wcount", 32'(write_count), 32'd0);

    // Randomized traffic against the reference model
    @(negedge clk);
    pushed_n = 0;
    model_q.delete();
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (cyc < 300) ce = ((cyc % 4) == 3);
      else ce = ($urandom_range(0, 3) != 0);
      push_now = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        req_valid   = 1'b1;
        req_indexed = 1'($urandom_range(0, 1));
        req_addr    = 16'($urandom);
        req_index   = 4'($urandom);
        req_data    = 8'($urandom);
        if (req_ready) begin
          push_now = 1'b1;
          pushed_n++;
          model_q.push_back('{indexed: req_indexed, addr: req_addr, index: req_index, data: req_data});
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; push_now = 1'b0; ce = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #2;
      if (completed == pushed_n) break;
    end
    check_output("rnd_all_completed", 32'(completed), 32'(pushed_n));
    check_output("rnd_model_empty", 32'(model_q.size()), 32'd0);
    @(negedge clk);
    mon_en = 1'b0;

    // write_count wraps from FFFF to 0
    ce = 1'b0;
    force dut.write_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.write_count_q;
    @(negedge clk);
    check_output("wrap_preload", 32'(write_count), 32'hFFFF);
    req_valid = 1'b1; req_indexed = 1'b0; req_addr = 16'h4321; req_data = 8'h09; ce = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("wrap_write", 32'(bus_write), 32'd1);
    check_output("wrap_ain", 32'(bus_ain), 32'h4321);
    check_output("wrap_wcount", 32'(write_count), 32'h0000);
    repeat (4) @(posedge clk);
    #1;
    check_output("wrap_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
